// File: rtl/cache_mem_arbiter_if.sv
// ============================================================================
//  Module   : cache_mem_arbiter_if
//  Purpose  : I-cache / D-cache / physical-memory bundle for cache_mem_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;

    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;

    // Arbiter view
    modport slave (
        input  i_pmem_read, i_pmem_address,
        output i_pmem_rdata, i_pmem_resp,
        input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        output d_pmem_rdata, d_pmem_resp,
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    // Caches plus memory view
    modport master (
        output i_pmem_read, i_pmem_address,
        input  i_pmem_rdata, i_pmem_resp,
        output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
        input  d_pmem_rdata, d_pmem_resp,
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
// ============================================================================
//  Module   : cache_mem_arbiter
//  Purpose  : Shares one line-wide pmem port between I-cache and D-cache.
//             Define ARB_RR_EN for round-robin tie-break (default: D wins).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  wire logic               clk,
    input  wire logic               rst,
    cache_mem_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_served_d_q;   // 0 = I-cache, 1 = D-cache
    logic              mem_read_q;
    logic              mem_write_q;
    logic [ADDR_W-1:0] mem_address_q;
    logic [LINE_W-1:0] mem_wdata_q;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;

    assign w_i_req = bus.i_pmem_read;
    assign w_d_req = bus.d_pmem_read | bus.d_pmem_write;

`ifdef ARB_RR_EN
    // On a tie, hand the port to whichever side was not served last.
    assign w_grant_d = w_d_req & (~w_i_req | ~last_served_d_q);
`else
    assign w_grant_d = w_d_req;
    logic w_unused_last_served;
    assign w_unused_last_served = last_served_d_q;
`endif
    assign w_grant_i = w_i_req & ~w_grant_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            last_served_d_q <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_wdata_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        // A simultaneous read+write is treated as a writeback.
                        mem_address_q <= bus.d_pmem_address;
                        mem_wdata_q   <= bus.d_pmem_wdata;
                        mem_write_q   <= bus.d_pmem_write;
                        mem_read_q    <= ~bus.d_pmem_write;
                        state_q       <= ST_SERVE_D;
                    end else if (w_grant_i) begin
                        mem_address_q <= bus.i_pmem_address;
                        mem_write_q   <= 1'b0;
                        mem_read_q    <= 1'b1;
                        state_q       <= ST_SERVE_I;
                    end
                end
                ST_SERVE_I: begin
                    if (bus.mem_resp) begin
                        mem_read_q      <= 1'b0;
                        mem_write_q     <= 1'b0;
                        last_served_d_q <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                ST_SERVE_D: begin
                    if (bus.mem_resp) begin
                        mem_read_q      <= 1'b0;
                        mem_write_q     <= 1'b0;
                        last_served_d_q <= 1'b1;
                        state_q         <= ST_IDLE;
                    end
                end
                default: begin
                    mem_read_q  <= 1'b0;
                    mem_write_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_read     = mem_read_q;
    assign bus.mem_write    = mem_write_q;
    assign bus.mem_address  = mem_address_q;
    assign bus.mem_wdata    = mem_wdata_q;

    // Read data is a plain fan-out; only the response strobe is steered.
    assign bus.i_pmem_rdata = bus.mem_rdata;
    assign bus.d_pmem_rdata = bus.mem_rdata;
    assign bus.i_pmem_resp  = (state_q == ST_SERVE_I) & bus.mem_resp;
    assign bus.d_pmem_resp  = (state_q == ST_SERVE_D) & bus.mem_resp;

endmodule

`default_nettype wire

// File: tb/tb_cache_mem_arbiter.sv
// ============================================================================
//  Module   : tb_cache_mem_arbiter
//  Purpose  : Directed self-checking bench for cache_mem_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_mem_arbiter;

    localparam int C_ADDR_W = 32;
    localparam int C_LINE_W = 256;

    logic clk;
    logic rst;

    cache_mem_arbiter_if #(.ADDR_W(C_ADDR_W), .LINE_W(C_LINE_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(C_ADDR_W), .LINE_W(C_LINE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         i_rd;
        logic [31:0]  i_addr;
        logic         d_rd;
        logic         d_wr;
        logic [31:0]  d_addr;
        logic [255:0] d_wdata;
        int           delay;
        logic [255:0] rdata;
        logic         exp_d;
        logic         exp_rd;
        logic         exp_wr;
        logic [31:0]  exp_addr;
    } vec_t;

    vec_t vecs [6];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.i_pmem_read    = 1'b0;
        bus.i_pmem_address = '0;
        bus.d_pmem_read    = 1'b0;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_address = '0;
        bus.d_pmem_wdata   = '0;
        bus.mem_rdata      = '0;
        bus.mem_resp       = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] pat_a5;
        logic [255:0] pat_5a;
        logic         exp_d4;
        int           n;
        pat_a5 = {32{8'hA5}};
        pat_5a = {32{8'h5A}};

        vecs[0] = '{1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0, 256'h0, 4,
                    {8{32'hCAFE_0001}}, 1'b0, 1'b1, 1'b0, 32'h0000_0100};
        vecs[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200, pat_a5, 2,
                    {8{32'h1111_2222}}, 1'b1, 1'b0, 1'b1, 32'h0000_0200};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0400, 256'h0, 1,
                    {8{32'hDEAD_BEEF}}, 1'b1, 1'b1, 1'b0, 32'h0000_0400};
        vecs[3] = '{1'b1, 32'h0000_0500, 1'b1, 1'b0, 32'h0000_0600, 256'h0, 3,
                    {8{32'h0BAD_F00D}}, 1'b1, 1'b1, 1'b0, 32'h0000_0600};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0700, pat_5a, 2,
                    {8{32'h7777_0000}}, 1'b1, 1'b0, 1'b1, 32'h0000_0700};
        vecs[5] = '{1'b1, 32'h0000_0800, 1'b0, 1'b0, 32'h0, 256'h0, 1,
                    {8{32'h8888_9999}}, 1'b0, 1'b1, 1'b0, 32'h0000_0800};

        // Reset state, with a stray mem_resp that must not leak through
        drive_idle();
        rst = 1'b1;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = {8{32'h1234_5678}};
        repeat (3) @(negedge clk);
        check("rst mem_read",    256'(bus.mem_read),    256'(0));
        check("rst mem_write",   256'(bus.mem_write),   256'(0));
        check("rst mem_address", 256'(bus.mem_address), 256'(0));
        check("rst mem_wdata",   bus.mem_wdata,         256'(0));
        check("rst resps",       256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
        check("rst i_rdata pass", bus.i_pmem_rdata, {8{32'h1234_5678}});
        check("rst d_rdata pass", bus.d_pmem_rdata, {8{32'h1234_5678}});
        rst = 1'b0;
        @(negedge clk);
        check("idle stray resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
        bus.mem_resp = 1'b0;

        // Table-driven single transactions
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            bus.i_pmem_read    = vecs[v].i_rd;
            bus.i_pmem_address = vecs[v].i_addr;
            bus.d_pmem_read    = vecs[v].d_rd;
            bus.d_pmem_write   = vecs[v].d_wr;
            bus.d_pmem_address = vecs[v].d_addr;
            bus.d_pmem_wdata   = vecs[v].d_wdata;
            @(negedge clk);
            check($sformatf("v%0d mem_read", v),    256'(bus.mem_read),    256'(vecs[v].exp_rd));
            check($sformatf("v%0d mem_write", v),   256'(bus.mem_write),   256'(vecs[v].exp_wr));
            check($sformatf("v%0d mem_address", v), 256'(bus.mem_address), 256'(vecs[v].exp_addr));
            if (vecs[v].exp_wr)
                check($sformatf("v%0d mem_wdata", v), bus.mem_wdata, vecs[v].d_wdata);
            for (int k = 1; k < vecs[v].delay; k++) begin
                @(negedge clk);
                check($sformatf("v%0d early resp", v), 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
                check($sformatf("v%0d hold addr", v), 256'(bus.mem_address), 256'(vecs[v].exp_addr));
            end
            @(negedge clk);
            bus.mem_rdata    = vecs[v].rdata;
            bus.mem_resp     = 1'b1;
            bus.i_pmem_read  = 1'b0;
            bus.d_pmem_read  = 1'b0;
            bus.d_pmem_write = 1'b0;
            #1;
            check($sformatf("v%0d i_resp", v), 256'(bus.i_pmem_resp), 256'(!vecs[v].exp_d));
            check($sformatf("v%0d d_resp", v), 256'(bus.d_pmem_resp), 256'(vecs[v].exp_d));
            check($sformatf("v%0d rdata", v), vecs[v].exp_d ? bus.d_pmem_rdata : bus.i_pmem_rdata,
                  vecs[v].rdata);
            @(negedge clk);
            bus.mem_resp = 1'b0;
            check($sformatf("v%0d idle strobes", v), 256'({bus.mem_read, bus.mem_write}), 256'(0));
        end

        // Tie: D first, then I after one idle cycle
        @(negedge clk);
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 32'h0000_0A40;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 32'h0000_0B80;
        @(negedge clk);
        check("tie first addr", 256'(bus.mem_address), 256'(32'h0000_0B80));
        bus.mem_resp    = 1'b1;
        bus.d_pmem_read = 1'b0;
        #1;
        check("tie d_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(2'b01));
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check("tie idle gap", 256'(bus.mem_read), 256'(0));
        @(negedge clk);
        check("tie second read", 256'(bus.mem_read), 256'(1));
        check("tie second addr", 256'(bus.mem_address), 256'(32'h0000_0A40));
        bus.mem_resp    = 1'b1;
        bus.i_pmem_read = 1'b0;
        #1;
        check("tie i_resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(2'b10));
        @(negedge clk);
        bus.mem_resp = 1'b0;

        // Requester inputs change mid-transaction; latched values hold
        @(negedge clk);
        bus.d_pmem_write   = 1'b1;
        bus.d_pmem_address = 32'h0000_0200;
        bus.d_pmem_wdata   = pat_a5;
        @(negedge clk);
        bus.d_pmem_address = 32'h0000_0300;
        bus.d_pmem_wdata   = pat_5a;
        bus.d_pmem_write   = 1'b0;
        bus.d_pmem_read    = 1'b1;
        repeat (2) @(negedge clk);
        check("mid addr held",  256'(bus.mem_address), 256'(32'h0000_0200));
        check("mid wdata held", bus.mem_wdata, pat_a5);
        check("mid op held",    256'({bus.mem_read, bus.mem_write}), 256'(2'b01));
        bus.mem_resp    = 1'b1;
        bus.d_pmem_read = 1'b0;
        #1;
        check("mid d_resp", 256'(bus.d_pmem_resp), 256'(1));
        @(negedge clk);
        bus.mem_resp = 1'b0;

        // Reset during SERVE_I
        @(negedge clk);
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 32'h0000_0900;
        @(negedge clk);
        check("rstmid granted", 256'(bus.mem_read), 256'(1));
        bus.i_pmem_read = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid mem_read", 256'(bus.mem_read), 256'(0));
        check("rstmid no resp",  256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
        rst = 1'b0;
        bus.mem_resp = 1'b1;
        #1;
        check("rstmid stray resp", 256'({bus.i_pmem_resp, bus.d_pmem_resp}), 256'(0));
        @(negedge clk);
        bus.mem_resp = 1'b0;
        check("rstmid still idle", 256'({bus.mem_read, bus.mem_write}), 256'(0));
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 32'h0000_0940;
        @(negedge clk);
        check("rstmid regrant", 256'(bus.mem_address), 256'(32'h0000_0940));
        bus.mem_resp    = 1'b1;
        bus.i_pmem_read = 1'b0;
        #1;
        check("rstmid regrant resp", 256'(bus.i_pmem_resp), 256'(1));
        @(negedge clk);
        bus.mem_resp = 1'b0;

        // Both request continuously for four transactions from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_pmem_read    = 1'b1;
        bus.i_pmem_address = 32'h0000_0B00;
        bus.d_pmem_read    = 1'b1;
        bus.d_pmem_address = 32'h0000_0A00;
        for (int t = 0; t < 4; t++) begin
`ifdef ARB_RR_EN
            exp_d4 = (t % 2 == 0);
`else
            exp_d4 = 1'b1;
`endif
            n = 0;
            while (!(bus.mem_read || bus.mem_write) && n < 5) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("cont%0d grant seen", t), 256'(bus.mem_read), 256'(1));
            check($sformatf("cont%0d addr", t), 256'(bus.mem_address),
                  256'(exp_d4 ? 32'h0000_0A00 : 32'h0000_0B00));
            @(negedge clk);
            bus.mem_resp = 1'b1;
            #1;
            check($sformatf("cont%0d resp", t), 256'({bus.i_pmem_resp, bus.d_pmem_resp}),
                  256'(exp_d4 ? 2'b01 : 2'b10));
            @(negedge clk);
            bus.mem_resp = 1'b0;
        end
        drive_idle();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
